bus_bridge_n: RTL and testbench



---
 rtl/bus_bridge_pkg.sv | 36 +++
 rtl/bus_bridge_decode.sv | 41 ++++
 rtl/bus_bridge_n.sv | 209 ++++++++++++++++++++
 tb/tb_bus_bridge_n.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg
//   Shared definitions for the CPU-to-peripheral bridge: bus widths,
//   FSM state encoding, default slave address windows and a helper
//   that sizes slave-index fields.
//   No ports (package).
package bus_bridge_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Default windows, inclusive on both ends.
    localparam logic [AW-1:0] DM_BASE   = 32'h0000_0000;
    localparam logic [AW-1:0] DM_LIMIT  = 32'h0000_2fff;
    localparam logic [AW-1:0] TC0_BASE  = 32'h0000_7f00;
    localparam logic [AW-1:0] TC0_LIMIT = 32'h0000_7f0b;
    localparam logic [AW-1:0] TC1_BASE  = 32'h0000_7f10;
    localparam logic [AW-1:0] TC1_LIMIT = 32'h0000_7f1b;
    localparam logic [AW-1:0] INT_BASE  = 32'h0000_7f20;
    localparam logic [AW-1:0] INT_LIMIT = 32'h0000_7f23;

    // Slot i lives at [32i+31:32i]: DM is slot 0, INT is slot 3.
    localparam logic [4*AW-1:0] DEF_SLV_BASE  = {INT_BASE,  TC1_BASE,  TC0_BASE,  DM_BASE};
    localparam logic [4*AW-1:0] DEF_SLV_LIMIT = {INT_LIMIT, TC1_LIMIT, TC0_LIMIT, DM_LIMIT};

    // Width of a slave index field; never zero, even for a single slave.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_bridge_decode.sv
// bus_bridge_decode
//   Combinational address decoder. Compares an address against N_SLV
//   inclusive [base, limit] windows; on overlap the lowest index wins.
//   Ports:
//     addr_i    in   AW        byte address
//     hit_o     out  1         address falls in at least one window
//     idx_o     out  IW        index of the winning window (0 on miss)
//     onehot_o  out  N_SLV     one-hot of the winning window (0 on miss)
module bus_bridge_decode
    import bus_bridge_pkg::*;
#(
    parameter int unsigned           N_SLV     = 4,
    parameter logic [N_SLV*AW-1:0]   SLV_BASE  = DEF_SLV_BASE,
    parameter logic [N_SLV*AW-1:0]   SLV_LIMIT = DEF_SLV_LIMIT,
    localparam int unsigned          IW        = idx_w(N_SLV)
) (
    input  logic [AW-1:0]    addr_i,
    output logic             hit_o,
    output logic [IW-1:0]    idx_o,
    output logic [N_SLV-1:0] onehot_o
);

    always_comb begin
        logic found;
        found    = 1'b0;
        hit_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (!found &&
                addr_i >= SLV_BASE[i*AW +: AW] &&
                addr_i <= SLV_LIMIT[i*AW +: AW]) begin
                found       = 1'b1;
                hit_o       = 1'b1;
                idx_o       = IW'(i);
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_bridge_n.sv
// bus_bridge_n
//   Registered CPU-to-peripheral bridge. Decodes a CPU access against
//   N_SLV windows, forwards it to one slave with a ready handshake, stalls
//   the CPU until completion and returns read data or a bus error.
//   Optional feature macro: BUS_BRIDGE_TIMEOUT_EN -- when defined, an ACCESS
//   that sees no slv_ready for TIMEOUT cycles completes with cpu_err=1.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     cpu_req/addr/byteen/wdata   CPU access (byteen=0 means read)
//     cpu_stall             CPU freeze
//     cpu_rvalid            one-cycle completion strobe
//     cpu_rdata/err/err_store     completion data and status
//     slv_sel/slv_we        one-hot select / write strobe
//     slv_addr/byteen/wdata registered word address, enables, data
//     slv_rdata/slv_ready   per-slave read data and completion
module bus_bridge_n
    import bus_bridge_pkg::*;
#(
    parameter int unsigned           N_SLV     = 4,
    parameter logic [N_SLV*AW-1:0]   SLV_BASE  = DEF_SLV_BASE,
    parameter logic [N_SLV*AW-1:0]   SLV_LIMIT = DEF_SLV_LIMIT,
    parameter int unsigned           TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_req,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [3:0]          cpu_byteen,
    input  logic [DW-1:0]       cpu_wdata,
    output logic                cpu_stall,
    output logic                cpu_rvalid,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_err,
    output logic                cpu_err_store,
    output logic [N_SLV-1:0]    slv_sel,
    output logic [N_SLV-1:0]    slv_we,
    output logic [AW-3:0]       slv_addr,
    output logic [3:0]          slv_byteen,
    output logic [DW-1:0]       slv_wdata,
    input  logic [N_SLV*DW-1:0] slv_rdata,
    input  logic [N_SLV-1:0]    slv_ready
);

    localparam int unsigned IW = idx_w(N_SLV);

    // Out-of-range TIMEOUT leaves this marker block in the elaborated
    // hierarchy; it carries no logic.
    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_out_of_range
    end

    state_e             state_q, state_d;
    logic [AW-3:0]      addr_q,  addr_d;
    logic [3:0]         be_q,    be_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic [IW-1:0]      idx_q,   idx_d;
    logic [N_SLV-1:0]   sel_q,   sel_d;
    logic               err_q,   err_d;
    logic               st_q,    st_d;

    logic               dec_hit;
    logic [IW-1:0]      dec_idx;
    logic [N_SLV-1:0]   dec_onehot;

    logic               hit_ready;
    logic [DW-1:0]      hit_rdata;
    logic               is_write;

    bus_bridge_decode #(
        .N_SLV     (N_SLV),
        .SLV_BASE  (SLV_BASE),
        .SLV_LIMIT (SLV_LIMIT)
    ) u_decode (
        .addr_i   (cpu_addr),
        .hit_o    (dec_hit),
        .idx_o    (dec_idx),
        .onehot_o (dec_onehot)
    );

    assign is_write = |be_q;

    // Only the selected slave's ready/data matter; the rest are ignored.
    always_comb begin
        hit_ready = 1'b0;
        hit_rdata = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (idx_q == IW'(i)) begin
                hit_ready = slv_ready[i];
                hit_rdata = slv_rdata[i*DW +: DW];
            end
        end
    end

`ifdef BUS_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        err_d   = err_q;
        st_d    = st_q;
`ifdef BUS_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr[AW-1:2];
                    be_d    = cpu_byteen;
                    wdata_d = cpu_wdata;
                    idx_d   = dec_idx;
                    sel_d   = dec_onehot;
                    if (dec_hit) begin
                        state_d = ACCESS;
`ifdef BUS_BRIDGE_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        st_d    = |cpu_byteen;
                        rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (hit_ready) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    st_d    = 1'b0;
                    rdata_d = is_write ? '0 : hit_rdata;
                end
`ifdef BUS_BRIDGE_TIMEOUT_EN
                // TO_LAST is the TIMEOUT-th consecutive cycle without ready.
                else if (cnt_q == TO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    st_d    = is_write;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            st_q    <= st_d;
        end
    end

`ifdef BUS_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Stall is gated by reset_n so it drops with reset even while the
    // CPU keeps cpu_req asserted.
    assign cpu_stall     = reset_n & (((state_q == IDLE) & cpu_req) | (state_q == ACCESS));
    assign cpu_rvalid    = (state_q == RESP);
    assign cpu_rdata     = cpu_rvalid ? rdata_q : '0;
    assign cpu_err       = cpu_rvalid & err_q;
    assign cpu_err_store = cpu_rvalid & st_q;

    assign slv_sel    = (state_q == ACCESS) ? sel_q : '0;
    assign slv_we     = ((state_q == ACCESS) && is_write) ? sel_q : '0;
    assign slv_addr   = addr_q;
    assign slv_byteen = be_q;
    assign slv_wdata  = wdata_q;

endmodule

// File: tb/tb_bus_bridge_n.sv
// tb_bus_bridge_n
//   Self-checking bench for bus_bridge_n (default parameters). A reference
//   model computes, per access, the target window, completion cycle and
//   response from the address map and slave wait count; the bench drives
//   the slave side from the same wait count and checks every cycle.
//   Honours BUS_BRIDGE_TIMEOUT_EN for the never-ready case.
module tb_bus_bridge_n;

    localparam int NS  = 4;
    localparam int TMO = 15;
`ifdef BUS_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req;
    logic [31:0]   cpu_addr;
    logic [3:0]    cpu_byteen;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          cpu_err;
    logic          cpu_err_store;
    logic [NS-1:0] slv_sel;
    logic [NS-1:0] slv_we;
    logic [29:0]   slv_addr;
    logic [3:0]    slv_byteen;
    logic [31:0]   slv_wdata;
    logic [NS*32-1:0] slv_rdata;
    logic [NS-1:0] slv_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] sdata [NS];
    int unsigned win_lo [NS] = '{32'h0000_0000, 32'h0000_7f00, 32'h0000_7f10, 32'h0000_7f20};
    int unsigned win_hi [NS] = '{32'h0000_2fff, 32'h0000_7f0b, 32'h0000_7f1b, 32'h0000_7f23};

    bus_bridge_n dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_byteen    (cpu_byteen),
        .cpu_wdata     (cpu_wdata),
        .cpu_stall     (cpu_stall),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .cpu_err       (cpu_err),
        .cpu_err_store (cpu_err_store),
        .slv_sel       (slv_sel),
        .slv_we        (slv_we),
        .slv_addr      (slv_addr),
        .slv_byteen    (slv_byteen),
        .slv_wdata     (slv_wdata),
        .slv_rdata     (slv_rdata),
        .slv_ready     (slv_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Lowest matching window wins; -1 means unmapped.
    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if (a >= win_lo[i] && a <= win_hi[i]) return i;
        return -1;
    endfunction

    // One CPU access, started at posedge+1. waits = ACCESS cycles before the
    // target slave raises ready. abort_at >= 0 asserts reset in that cycle.
    task automatic run_access(input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input int waits, input int abort_at);
        int          idx;
        bit          hit, wr, exp_err;
        int          lat;
        logic [31:0] exp_rd;
        logic [3:0]  exp_oh;
        logic [3:0]  act_oh;
        idx = model_decode(addr);
        hit = (idx >= 0);
        wr  = (be != 4'h0);
        for (int s = 0; s < NS; s++) begin
            sdata[s] = $urandom;
            slv_rdata[s*32 +: 32] = sdata[s];
        end
        exp_oh = 4'h0;
        if (hit) exp_oh[idx] = 1'b1;
        if (!hit) begin
            lat = 1; exp_err = 1'b1; exp_rd = 32'h0;
        end else if (TO_EN && waits >= TMO) begin
            lat = TMO + 1; exp_err = 1'b1; exp_rd = 32'h0;
        end else begin
            lat = 2 + waits; exp_err = 1'b0; exp_rd = wr ? 32'h0 : sdata[idx];
        end
        cpu_req = 1'b1; cpu_addr = addr; cpu_byteen = be; cpu_wdata = wd;
        for (int c = 0; c <= lat; c++) begin
            for (int s = 0; s < NS; s++)
                slv_ready[s] = (s == idx) ? (c >= 1 && c - 1 == waits) : 1'($urandom_range(0, 1));
            if (c == lat) begin
                // A request shown during the response cycle must not be taken.
                cpu_req    = 1'($urandom_range(0, 1));
                cpu_addr   = $urandom;
                cpu_byteen = 4'($urandom);
            end
            @(negedge clk);
            act_oh = (c >= 1 && c < lat && hit) ? exp_oh : 4'h0;
            chk("stall", cpu_stall, c < lat);
            chk("rvalid", cpu_rvalid, c == lat);
            chk("slv_sel", slv_sel, act_oh);
            chk("slv_we", slv_we, wr ? act_oh : 4'h0);
            if (c >= 1) begin
                chk("slv_addr", slv_addr, {2'b00, addr[31:2]});
                chk("slv_byteen", slv_byteen, be);
                chk("slv_wdata", slv_wdata, wd);
            end
            if (c == lat) begin
                chk("rdata", cpu_rdata, exp_rd);
                chk("err", cpu_err, exp_err);
                chk("err_store", cpu_err_store, exp_err && wr);
            end
            if (c == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_stall", cpu_stall, 0);
                chk("rst_sel", slv_sel, 0);
                chk("rst_we", slv_we, 0);
                chk("rst_rvalid", cpu_rvalid, 0);
                chk("rst_addr", slv_addr, 0);
                chk("rst_byteen", slv_byteen, 0);
                cpu_req = 1'b0;
                slv_ready = '0;
                @(posedge clk); #1;
                chk("rst_hold_sel", slv_sel, 0);
                @(negedge clk) reset_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        for (int k = 0; k < n; k++) begin
            slv_ready = 4'($urandom);
            @(negedge clk);
            chk("idle_stall", cpu_stall, 0);
            chk("idle_rvalid", cpu_rvalid, 0);
            chk("idle_sel", slv_sel, 0);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int m;
        m = $urandom_range(0, 5);
        if (m < NS) return win_lo[m] + $urandom_range(0, win_hi[m] - win_lo[m]);
        if (m == 4) return 32'($urandom_range(32'h3000, 32'h7eff));
        return 32'h0001_0000 + $urandom_range(0, 32'hffff);
    endfunction

    initial begin
        reset_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_byteen = '0;
        cpu_wdata = '0; slv_rdata = '0; slv_ready = '0;
        #3;
        chk("por_stall", cpu_stall, 0);
        chk("por_rvalid", cpu_rvalid, 0);
        chk("por_rdata", cpu_rdata, 0);
        chk("por_err", cpu_err, 0);
        chk("por_sel", slv_sel, 0);
        chk("por_we", slv_we, 0);
        chk("por_wdata", slv_wdata, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // DM zero-wait read.
        run_access(32'h0000_1000, 4'h0, 32'h0, 0, -1);
        idle(1);
        // TC0 write, three wait cycles.
        run_access(32'h0000_7f04, 4'hF, 32'h64, 3, -1);
        idle(1);
        // Unmapped read and write.
        run_access(32'h0000_5000, 4'h0, 32'h0, 0, -1);
        idle(1);
        run_access(32'h0000_5000, 4'h3, 32'h1234, 0, -1);
        idle(1);
        // TC1 never ready: timeout abort, or a long stall ended by reset.
        if (TO_EN) run_access(32'h0000_7f10, 4'h0, 32'h0, 1000, -1);
        else       run_access(32'h0000_7f10, 4'h0, 32'h0, 1000, 105);
        idle(1);
        // Reset during TC0 ACCESS, then a normal request.
        run_access(32'h0000_7f00, 4'hF, 32'hA5A5_5A5A, 5, 2);
        run_access(32'h0000_7f08, 4'h0, 32'h0, 1, -1);
        idle(1);
        // Back-to-back DM then INT.
        run_access(32'h0000_0010, 4'h0, 32'h0, 0, -1);
        run_access(32'h0000_7f20, 4'h0, 32'h0, 0, -1);
        idle(1);

        for (int n = 0; n < 200; n++) begin
            run_access(rand_addr(), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                       $urandom, $urandom_range(0, 4), -1);
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
